// File: rtl/conv_window_mac.sv
// conv_window_mac: loads an M_LEN x M_LEN signed kernel row by row, then
// streams image rows through a sliding window and emits one multiply-accumulate
// result per accepted row once the window is full. The datapath has three
// register stages: window, products and the saturated sum.
// Optional feature: define CONV_WINDOW_MAC_RELU_EN to clamp negative results to 0.
module conv_window_mac #(
    parameter int BIT_LEN  = 8,
    parameter int M_LEN    = 3,
    parameter int CONV_LEN = 20
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_k_valid,
    input  logic [BIT_LEN*M_LEN-1:0]   i_data_kernel,
    input  logic                       i_img_valid,
    output logic                       o_img_ready,
    input  logic [BIT_LEN*M_LEN-1:0]   i_data_img,
    input  logic                       i_flush,
    output logic [CONV_LEN-1:0]        o_data,
    output logic                       o_valid
);

    localparam int N_TAPS = M_LEN * M_LEN;
    localparam int PROD_W = 2 * BIT_LEN;
    localparam int SUM_W  = 2 * BIT_LEN + $clog2(N_TAPS);
    localparam int CNT_W  = $clog2(M_LEN + 1);

    typedef enum logic [1:0] {S_LOAD, S_FILL, S_RUN} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           k_cnt_q, k_cnt_d;
    logic [CNT_W-1:0]           fill_q, fill_d;
    logic signed [BIT_LEN-1:0]  kernel_q [M_LEN][M_LEN];
    logic signed [BIT_LEN-1:0]  kernel_d [M_LEN][M_LEN];
    logic signed [BIT_LEN-1:0]  window_q [M_LEN][M_LEN];
    logic signed [BIT_LEN-1:0]  window_d [M_LEN][M_LEN];
    logic signed [PROD_W-1:0]   prod_q [N_TAPS];
    logic signed [PROD_W-1:0]   prod_d [N_TAPS];
    logic                       trig_q, trig_d;
    logic                       pv_q, pv_d;
    logic                       ov_q, ov_d;
    logic                       img_ready_q, img_ready_d;
    logic [CONV_LEN-1:0]        data_q, data_d;
    logic                       kill;

    logic signed [BIT_LEN-1:0]  k_row [M_LEN];
    logic signed [BIT_LEN-1:0]  img_row [M_LEN];
    logic signed [SUM_W-1:0]    sum_full;
    logic signed [CONV_LEN-1:0] sat_val;
    logic signed [CONV_LEN-1:0] result;

    // Split the packed row buses into per-lane signed elements.
    for (genvar gi = 0; gi < M_LEN; gi++) begin : g_lane
        assign k_row[gi]   = i_data_kernel[BIT_LEN*(gi+1)-1 : BIT_LEN*gi];
        assign img_row[gi] = i_data_img[BIT_LEN*(gi+1)-1 : BIT_LEN*gi];
    end

    // Control: kernel loading, window shifting, flush/reload and compute trigger.
    always_comb begin
        state_d  = state_q;
        k_cnt_d  = k_cnt_q;
        fill_d   = fill_q;
        kernel_d = kernel_q;
        window_d = window_q;
        trig_d   = 1'b0;
        kill     = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (i_k_valid) begin
                    for (int r = 0; r < M_LEN; r++) begin
                        if (CNT_W'(r) == k_cnt_q) kernel_d[r] = k_row;
                    end
                    if (k_cnt_q == CNT_W'(M_LEN - 1)) begin
                        k_cnt_d = '0;
                        fill_d  = '0;
                        state_d = S_FILL;
                    end else begin
                        k_cnt_d = k_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (i_k_valid) begin
                    // A new kernel restarts loading; row 0 is taken right away.
                    kernel_d[0] = k_row;
                    k_cnt_d     = CNT_W'(1);
                    fill_d      = '0;
                    kill        = 1'b1;
                    state_d     = S_LOAD;
                    for (int r = 0; r < M_LEN; r++)
                        for (int j = 0; j < M_LEN; j++) window_d[r][j] = '0;
                end else if (i_flush) begin
                    fill_d  = '0;
                    kill    = 1'b1;
                    state_d = S_FILL;
                    for (int r = 0; r < M_LEN; r++)
                        for (int j = 0; j < M_LEN; j++) window_d[r][j] = '0;
                end else if (i_img_valid) begin
                    for (int r = 0; r < M_LEN - 1; r++) window_d[r] = window_q[r + 1];
                    window_d[M_LEN-1] = img_row;
                    if (state_q == S_FILL) begin
                        if (fill_q == CNT_W'(M_LEN - 1)) begin
                            fill_d  = '0;
                            trig_d  = 1'b1;
                            state_d = S_RUN;
                        end else begin
                            fill_d = fill_q + 1'b1;
                        end
                    end else begin
                        trig_d = 1'b1;
                    end
                end
            end
        endcase
        img_ready_d = (state_d != S_LOAD);
    end

    // Element-wise signed products of the current window and kernel.
    for (genvar gi = 0; gi < M_LEN; gi++) begin : g_row
        for (genvar gj = 0; gj < M_LEN; gj++) begin : g_col
            assign prod_d[gi*M_LEN+gj] = PROD_W'(window_q[gi][gj]) * PROD_W'(kernel_q[gi][gj]);
        end
    end

    // Full-precision adder tree over the registered products.
    always_comb begin
        sum_full = '0;
        for (int t = 0; t < N_TAPS; t++) sum_full = sum_full + SUM_W'(prod_q[t]);
    end

    // Fit the full-precision sum into the output width.
    if (CONV_LEN < SUM_W) begin : g_sat
        localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-CONV_LEN+1){1'b0}}, {(CONV_LEN-1){1'b1}}};
        localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-CONV_LEN+1){1'b1}}, {(CONV_LEN-1){1'b0}}};
        // Clamp to the signed output range.
        always_comb begin
            if (sum_full > SAT_MAX)      sat_val = SAT_MAX[CONV_LEN-1:0];
            else if (sum_full < SAT_MIN) sat_val = SAT_MIN[CONV_LEN-1:0];
            else                         sat_val = sum_full[CONV_LEN-1:0];
        end
    end else if (CONV_LEN == SUM_W) begin : g_same
        assign sat_val = sum_full;
    end else begin : g_ext
        assign sat_val = {{(CONV_LEN-SUM_W){sum_full[SUM_W-1]}}, sum_full};
    end

    // Optional rectification, in the sum stage so latency is unchanged.
    always_comb begin
        result = sat_val;
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (sat_val[CONV_LEN-1]) result = '0;
`endif
    end

    // Pipeline valids are cleared by flush/reload so in-flight results vanish.
    always_comb begin
        pv_d   = trig_q && !kill;
        ov_d   = pv_q && !kill;
        data_d = ov_d ? result : data_q;
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_LOAD;
            k_cnt_q     <= '0;
            fill_q      <= '0;
            trig_q      <= 1'b0;
            pv_q        <= 1'b0;
            ov_q        <= 1'b0;
            img_ready_q <= 1'b0;
            data_q      <= '0;
            for (int r = 0; r < M_LEN; r++) begin
                for (int j = 0; j < M_LEN; j++) begin
                    kernel_q[r][j] <= '0;
                    window_q[r][j] <= '0;
                end
            end
            for (int t = 0; t < N_TAPS; t++) prod_q[t] <= '0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            fill_q      <= fill_d;
            trig_q      <= trig_d;
            pv_q        <= pv_d;
            ov_q        <= ov_d;
            img_ready_q <= img_ready_d;
            data_q      <= data_d;
            kernel_q    <= kernel_d;
            window_q    <= window_d;
            prod_q      <= prod_d;
        end
    end

    assign o_img_ready = img_ready_q;
    assign o_valid     = ov_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac: a default instance (CONV_LEN=20) and a
// narrow instance (CONV_LEN=12) checked against hand-computed results.
module tb_conv_window_mac;

`ifdef CONV_WINDOW_MAC_RELU_EN
    localparam int EXP_M1143 = 0;
    localparam int EXP_M2048 = 0;
`else
    localparam int EXP_M1143 = -1143;
    localparam int EXP_M2048 = -2048;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_reset = 1'b1, a_kv = 1'b0, a_iv = 1'b0, a_fl = 1'b0;
    logic [23:0] a_kd = '0, a_id = '0;
    logic        a_ready, a_valid;
    logic [19:0] a_data;

    logic        b_reset = 1'b1, b_kv = 1'b0, b_iv = 1'b0, b_fl = 1'b0;
    logic [23:0] b_kd = '0, b_id = '0;
    logic        b_ready, b_valid;
    logic [11:0] b_data;

    conv_window_mac #(.BIT_LEN(8), .M_LEN(3), .CONV_LEN(20)) dut_a (
        .i_clk(clk), .i_reset(a_reset), .i_k_valid(a_kv), .i_data_kernel(a_kd),
        .i_img_valid(a_iv), .o_img_ready(a_ready), .i_data_img(a_id),
        .i_flush(a_fl), .o_data(a_data), .o_valid(a_valid));

    conv_window_mac #(.BIT_LEN(8), .M_LEN(3), .CONV_LEN(12)) dut_b (
        .i_clk(clk), .i_reset(b_reset), .i_k_valid(b_kv), .i_data_kernel(b_kd),
        .i_img_valid(b_iv), .o_img_ready(b_ready), .i_data_img(b_id),
        .i_flush(b_fl), .o_data(b_data), .o_valid(b_valid));

    typedef struct {int val; int at;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int n_tests = 0;
    int n_fail  = 0;

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (a_valid === 1'b1) begin
            n_tests++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected_valid: got o_data=%0d at cycle %0d, required no result", $signed(a_data), cyc);
            end else begin
                ea = qa.pop_front();
                if ($signed(a_data) != ea.val || cyc != ea.at) begin
                    n_fail++;
                    $display("FAIL a_result: got %0d at cycle %0d, required %0d at cycle %0d", $signed(a_data), cyc, ea.val, ea.at);
                end else begin
                    $display("[TB] a result %0d at cycle %0d ok", ea.val, cyc);
                end
            end
        end
    end

    // Monitor for the narrow instance.
    always @(negedge clk) begin
        if (b_valid === 1'b1) begin
            n_tests++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_valid: got o_data=%0d at cycle %0d, required no result", $signed(b_data), cyc);
            end else begin
                eb = qb.pop_front();
                if ($signed(b_data) != eb.val || cyc != eb.at) begin
                    n_fail++;
                    $display("FAIL b_result: got %0d at cycle %0d, required %0d at cycle %0d", $signed(b_data), cyc, eb.val, eb.at);
                end else begin
                    $display("[TB] b result %0d at cycle %0d ok", eb.val, cyc);
                end
            end
        end
    end

    function automatic logic [23:0] rw(input int x);
        return {3{x[7:0]}};
    endfunction

    task automatic step_a(input logic rst, input logic kv, input logic [23:0] kd,
                          input logic iv, input logic [23:0] id, input logic fl);
        @(negedge clk);
        a_reset = rst; a_kv = kv; a_kd = kd; a_iv = iv; a_id = id; a_fl = fl;
    endtask

    task automatic step_b(input logic rst, input logic kv, input logic [23:0] kd,
                          input logic iv, input logic [23:0] id, input logic fl);
        @(negedge clk);
        b_reset = rst; b_kv = kv; b_kd = kd; b_iv = iv; b_id = id; b_fl = fl;
    endtask

    // Row issued at this negedge is accepted at the next edge; result shows 3 cycles later.
    task automatic push_a(input int v);
        qa.push_back('{val: v, at: cyc + 3});
    endtask

    task automatic push_b(input int v);
        qb.push_back('{val: v, at: cyc + 3});
    endtask

    task automatic chk(input string name, input int got, input int req);
        n_tests++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end else begin
            $display("[TB] check %s = %0d ok", name, got);
        end
    endtask

    initial begin
        // ---------------- default instance ----------------
        step_a(1, 0, 0, 0, 0, 0);
        step_a(1, 0, 0, 0, 0, 0);
        step_a(0, 0, 0, 1, rw(9), 0);           // image during S_LOAD: ignored
        chk("a_reset_valid", int'(a_valid), 0);
        chk("a_reset_data", int'($signed(a_data)), 0);
        chk("a_reset_ready", int'(a_ready), 0);
        step_a(0, 1, rw(1), 1, rw(9), 0);
        chk("a_ready_in_load", int'(a_ready), 0);
        step_a(0, 1, rw(2), 0, 0, 0);
        step_a(0, 1, rw(3), 0, 0, 0);
        step_a(0, 0, 0, 1, rw(1), 0);
        chk("a_ready_after_load", int'(a_ready), 1);
        step_a(0, 0, 0, 1, rw(2), 0);
        step_a(0, 0, 0, 1, rw(3), 0); push_a(42);
        step_a(0, 0, 0, 1, rw(4), 0); push_a(60);
        step_a(0, 0, 0, 1, rw(5), 0); push_a(78);
        repeat (5) step_a(0, 0, 0, 0, 0, 0);
        chk("a_hold_data", int'($signed(a_data)), 78);
        chk("a_hold_valid", int'(a_valid), 0);

        // Flush with two results in flight, plus a row offered during the flush.
        step_a(0, 0, 0, 1, rw(6), 0);
        step_a(0, 0, 0, 1, rw(7), 0);
        step_a(0, 0, 0, 1, rw(9), 1);
        step_a(0, 0, 0, 1, rw(1), 0);
        step_a(0, 0, 0, 1, rw(2), 0);
        step_a(0, 0, 0, 1, rw(3), 0); push_a(42);
        repeat (5) step_a(0, 0, 0, 0, 0, 0);

        // Kernel reload during S_RUN (with flush asserted too) kills in-flight rows.
        step_a(0, 0, 0, 1, rw(4), 0);
        step_a(0, 0, 0, 1, rw(5), 0);
        step_a(0, 1, rw(255), 0, 0, 1);
        step_a(0, 1, rw(255), 1, rw(127), 0);
        chk("a_ready_reload1", int'(a_ready), 0);
        step_a(0, 1, rw(255), 0, 0, 0);
        chk("a_ready_reload2", int'(a_ready), 0);
        step_a(0, 0, 0, 1, rw(127), 0);
        chk("a_ready_reload_done", int'(a_ready), 1);
        step_a(0, 0, 0, 1, rw(127), 0);
        step_a(0, 0, 0, 1, rw(127), 0); push_a(EXP_M1143);
        repeat (5) step_a(0, 0, 0, 0, 0, 0);

        // Reset mid-stream loses the in-flight result.
        step_a(0, 0, 0, 1, rw(127), 0);
        step_a(1, 0, 0, 0, 0, 0);
        step_a(0, 0, 0, 1, rw(50), 0);
        chk("a_midreset_valid", int'(a_valid), 0);
        chk("a_midreset_data", int'($signed(a_data)), 0);
        chk("a_midreset_ready", int'(a_ready), 0);
        step_a(0, 1, rw(1), 1, rw(50), 0);
        step_a(0, 1, rw(2), 0, 0, 0);
        step_a(0, 1, rw(3), 0, 0, 0);
        step_a(0, 0, 0, 1, rw(1), 0);
        step_a(0, 0, 0, 1, rw(2), 0);
        step_a(0, 0, 0, 1, rw(3), 0); push_a(42);
        repeat (6) step_a(0, 0, 0, 0, 0, 0);

        // ---------------- narrow instance ----------------
        step_b(1, 0, 0, 0, 0, 0);
        step_b(0, 1, rw(128), 0, 0, 0);
        chk("b_reset_ready", int'(b_ready), 0);
        step_b(0, 1, rw(128), 0, 0, 0);
        step_b(0, 1, rw(128), 0, 0, 0);
        step_b(0, 0, 0, 1, rw(128), 0);
        step_b(0, 0, 0, 1, rw(128), 0);
        step_b(0, 0, 0, 1, rw(128), 0); push_b(2047);
        repeat (5) step_b(0, 0, 0, 0, 0, 0);
        step_b(0, 0, 0, 0, 0, 1);
        step_b(0, 0, 0, 1, rw(127), 0);
        step_b(0, 0, 0, 1, rw(127), 0);
        step_b(0, 0, 0, 1, rw(127), 0); push_b(EXP_M2048);
        repeat (8) step_b(0, 0, 0, 0, 0, 0);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
